rx_job_assembler: RTL and testbench

RX_JOB_ASSEMBLER -- requirements
Module: rx_job_assembler

---
 rtl/rx_job_assembler.sv | 178 +++++++++++++++++
 tb/tb_rx_job_assembler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_job_assembler.sv
// Assembles a SYNC_BYTE-led UART frame into NUM_WORDS 32-bit words plus an XOR checksum; optional RX_TIMEOUT_EN adds an inter-byte timeout.
// Latency: word_wr, job_ready and job_error are registered and appear one cycle after the data_ready strobe that causes them.
// Backpressure: none on the byte stream; a completed job is held until job_ack, and bytes arriving meanwhile are dropped.
module rx_job_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         NUM_WORDS      = 20,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        data_ready,
    input  logic [7:0]  rx_data,
    input  logic        framing_error,
    input  logic        job_ack,
    output logic [31:0] word_out,
    output logic [4:0]  word_addr,
    output logic        word_wr,
    output logic        job_ready,
    output logic        job_error,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

    logic [1:0]  state_q,     state_d;
    logic [23:0] shift_q,     shift_d;
    logic [1:0]  byte_cnt_q,  byte_cnt_d;
    logic [4:0]  word_idx_q,  word_idx_d;
    logic [7:0]  xor_q,       xor_d;
    logic [31:0] word_out_q,  word_out_d;
    logic [4:0]  word_addr_q, word_addr_d;
    logic        word_wr_q,   word_wr_d;
    logic        job_ready_q, job_ready_d;
    logic        job_error_q, job_error_d;
    logic        tmo_hit;
    logic        in_frame;

    assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a frame.
    assign tmo_hit = in_frame && !data_ready && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_q <= '0;
        end else if (data_ready || !in_frame || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    // Never true; keeps TIMEOUT_CYCLES referenced when the timeout is compiled out.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        xor_d       = xor_q;
        word_out_d  = word_out_q;
        word_addr_d = word_addr_q;
        word_wr_d   = 1'b0;
        job_ready_d = job_ready_q;
        job_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_ready && !framing_error && (rx_data == SYNC_BYTE)) begin
                    state_d    = ST_PAYLOAD;
                    byte_cnt_d = 2'd0;
                    word_idx_d = 5'd0;
                    xor_d      = 8'd0;
                end
            end

            ST_PAYLOAD: begin
                if (data_ready) begin
                    if (framing_error) begin
                        job_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        shift_d    = {shift_q[15:0], rx_data};
                        xor_d      = xor_q ^ rx_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            word_wr_d   = 1'b1;
                            word_out_d  = {shift_q, rx_data};
                            word_addr_d = word_idx_q;
                            if (word_idx_q == LAST_IDX) begin
                                state_d = ST_CHECK;
                            end else begin
                                word_idx_d = word_idx_q + 5'd1;
                            end
                        end
                    end
                end else if (tmo_hit) begin
                    job_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (data_ready) begin
                    if (framing_error || (rx_data != xor_q)) begin
                        job_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        job_ready_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    job_error_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_DONE: begin
                // Bytes are dropped here, including one that coincides with the ack.
                if (job_ack) begin
                    job_ready_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                job_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            xor_q       <= '0;
            word_out_q  <= '0;
            word_addr_q <= '0;
            word_wr_q   <= 1'b0;
            job_ready_q <= 1'b0;
            job_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            xor_q       <= xor_d;
            word_out_q  <= word_out_d;
            word_addr_q <= word_addr_d;
            word_wr_q   <= word_wr_d;
            job_ready_q <= job_ready_d;
            job_error_q <= job_error_d;
        end
    end

    assign word_out  = word_out_q;
    assign word_addr = word_addr_q;
    assign word_wr   = word_wr_q;
    assign job_ready = job_ready_q;
    assign job_error = job_error_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_job_assembler.sv
// Randomized and directed byte streams against a byte-list reference model of frame assembly.
module tb_rx_job_assembler;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        data_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        framing_error = 1'b0;
    logic        job_ack = 1'b0;
    logic [31:0] word_out;
    logic [4:0]  word_addr;
    logic        word_wr;
    logic        job_ready;
    logic        job_error;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    rx_job_assembler #(
        .SYNC_BYTE      (8'hA5),
        .NUM_WORDS      (20),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .data_ready    (data_ready),
        .rx_data       (rx_data),
        .framing_error (framing_error),
        .job_ack       (job_ack),
        .word_out      (word_out),
        .word_addr     (word_addr),
        .word_wr       (word_wr),
        .job_ready     (job_ready),
        .job_error     (job_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is the list of payload bytes collected after a sync byte.
    logic [7:0]  m_bytes[$];
    bit          m_in    = 1'b0;
    bit          m_ready = 1'b0;
    int          m_stall = 0;
    bit          e_wr;
    bit          e_err;
    logic [31:0] e_word;
    logic [4:0]  e_addr;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit dv, input logic [7:0] b, input bit fe, input bit ack);
        logic [7:0] x;
        int n;
        e_wr  = 1'b0;
        e_err = 1'b0;
        if (m_ready) begin
            if (ack) m_ready = 1'b0;
        end else if (!m_in) begin
            if (dv && !fe && b == 8'hA5) begin
                m_in = 1'b1;
                m_bytes.delete();
                m_stall = 0;
            end
        end else if (dv) begin
            m_stall = 0;
            if (m_bytes.size() < 80) begin
                if (fe) begin
                    e_err = 1'b1;
                    m_in  = 1'b0;
                end else begin
                    m_bytes.push_back(b);
                    n = m_bytes.size();
                    if (n % 4 == 0) begin
                        e_wr   = 1'b1;
                        e_word = {m_bytes[n-4], m_bytes[n-3], m_bytes[n-2], m_bytes[n-1]};
                        e_addr = 5'(n / 4 - 1);
                    end
                end
            end else begin
                x = 8'h00;
                foreach (m_bytes[i]) x = x ^ m_bytes[i];
                m_in = 1'b0;
                if (!fe && b == x) m_ready = 1'b1;
                else               e_err   = 1'b1;
            end
        end else begin
`ifdef RX_TIMEOUT_EN
            m_stall++;
            if (m_stall == TMO) begin
                e_err = 1'b1;
                m_in  = 1'b0;
            end
`endif
        end
    endtask

    // One clock: drive, let the DUT capture, then compare registered outputs with the model.
    task automatic cyc(input bit dv, input logic [7:0] b, input bit fe, input bit ack);
        @(negedge clk);
        data_ready    = dv;
        rx_data       = b;
        framing_error = fe;
        job_ack       = ack;
        model_step(dv, b, fe, ack);
        @(posedge clk);
        #1;
        data_ready    = 1'b0;
        framing_error = 1'b0;
        job_ack       = 1'b0;
        check_val("word_wr", {31'd0, word_wr}, {31'd0, e_wr});
        if (e_wr) begin
            check_val("word_out", word_out, e_word);
            check_val("word_addr", {27'd0, word_addr}, {27'd0, e_addr});
        end
        check_val("job_error", {31'd0, job_error}, {31'd0, e_err});
        check_val("job_ready", {31'd0, job_ready}, {31'd0, m_ready});
        check_val("busy", {31'd0, busy}, {31'd0, (m_in | m_ready)});
        check_val("wr_err_excl", {31'd0, (word_wr & job_error)}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fe, input int max_gap);
        cyc(1'b1, b, fe, 1'b0);
        repeat ($urandom_range(max_gap, 0)) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Sends sync + 80 payload bytes (+ checksum unless fe_at hits); seq gives 00..4F.
    task automatic send_frame(input bit seq, input int fe_at, input bit bad_ck, input int max_gap);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hA5, 1'b0, max_gap);
        for (int i = 0; i < 80; i++) begin
            b = seq ? 8'(i) : 8'($urandom_range(255, 0));
            send_byte(b, (i == fe_at), max_gap);
            if (i == fe_at) return;
            x = x ^ b;
        end
        if (bad_ck) x = x ^ 8'($urandom_range(255, 1));
        send_byte(x, 1'b0, max_gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_word_out"}, word_out, 32'd0);
        check_val({tag, "_word_addr"}, {27'd0, word_addr}, 32'd0);
        check_val({tag, "_flags"}, {26'd0, word_wr, job_ready, job_error, busy, 2'b00}, 32'd0);
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Sequential payload, correct checksum 0x00, then ack.
        send_frame(1'b1, -1, 1'b0, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Same payload, checksum 0x01.
        send_byte(8'hA5, 1'b0, 0);
        for (int i = 0; i < 80; i++) send_byte(8'(i), 1'b0, 1);
        send_byte(8'h01, 1'b0, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Leading garbage, then a good frame and ack.
        send_byte(8'h3C, 1'b0, 1);
        send_byte(8'h11, 1'b0, 1);
        send_frame(1'b1, -1, 1'b0, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // Framing error on sixth payload byte.
        send_frame(1'b1, 5, 1'b0, 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Extra sync bytes while a job is held, then ack together with a sync byte.
        send_frame(1'b0, -1, 1'b0, 0);
        send_byte(8'hA5, 1'b0, 1);
        send_byte(8'hA5, 1'b0, 1);
        cyc(1'b1, 8'hA5, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Long stall after ten payload bytes.
        send_byte(8'hA5, 1'b0, 0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(255, 0)), 1'b0, 0);
        repeat (TMO + 20) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        send_byte(8'hA5, 1'b0, 0);
        for (int i = 0; i < 13; i++) send_byte(8'($urandom_range(255, 0)), 1'b0, 0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        n_rst   = 1'b1;
        m_in    = 1'b0;
        m_ready = 1'b0;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Random frames with noise, occasional errors and random ack timing.
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(2, 0)) send_byte(8'($urandom_range(255, 0)), ($urandom_range(7, 0) == 0), 1);
            send_frame(1'b0, ($urandom_range(7, 0) == 0) ? int'($urandom_range(79, 0)) : -1,
                       ($urandom_range(3, 0) == 0), 2);
            repeat ($urandom_range(3, 0)) cyc(($urandom_range(1, 0) == 1), 8'($urandom_range(255, 0)), 1'b0, 1'b0);
            cyc(($urandom_range(1, 0) == 1), 8'hA5, 1'b0, 1'b1);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
